// File: rtl/einstein_sd_pkg.sv
// Shared types for the Einstein SD sector-channel arbiter.
//   NUM_DRIVES      : number of floppy drives sharing the hps_io channel
//   sd_arb_state_t  : arbiter FSM states
//   sd_dir_t        : transfer direction of a granted request
//   sd_grant_t      : latched grant (drive index, direction, LBA)
//   drv_onehot()    : drive index -> one-hot per-drive vector
package einstein_sd_pkg;

    localparam int NUM_DRIVES = 2;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        XFER,
        DONE
    } sd_arb_state_t;

    typedef enum logic {
        DIR_RD = 1'b0,
        DIR_WR = 1'b1
    } sd_dir_t;

    typedef struct packed {
        logic        idx;
        sd_dir_t     dir;
        logic [31:0] lba;
    } sd_grant_t;

    function automatic logic [NUM_DRIVES-1:0] drv_onehot(input logic idx);
        logic [NUM_DRIVES-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/sd_rr_pick.sv
// Combinational 2-way round-robin picker.
//   pending   in  2  per-drive request pending
//   last      in  1  index of the most recent grant
//   gnt_valid out 1  at least one request pending
//   gnt_idx   out 1  winning drive index
module sd_rr_pick (
    input  logic [1:0] pending,
    input  logic       last,
    output logic       gnt_valid,
    output logic       gnt_idx
);

    always_comb begin
        gnt_valid = |pending;
        gnt_idx   = 1'b0;
        case (pending)
            2'b01:   gnt_idx = 1'b0;
            2'b10:   gnt_idx = 1'b1;
            // Contest: the drive that did not win last time goes first.
            2'b11:   gnt_idx = ~last;
            default: gnt_idx = 1'b0;
        endcase
    end

endmodule

// File: rtl/sd_drive_arbiter.sv
// Shares the single hps_io SD sector channel between the two Einstein
// floppy drives. Level-held per-drive read/write requests are granted
// round-robin; the grant is latched and buffer traffic is steered to the
// granted drive only.
//   clk_sys, reset_n       system clock, synchronous active-low reset
//   drv_rd/drv_wr/drv_lba  per-drive requests and LBAs
//   drv_done/drv_err       per-drive completion / timeout pulses
//   drv_buff_wr            per-drive buffer write strobe
//   drv_buff_din           per-drive data for SD writes
//   sd_lba/sd_rd/sd_wr     request toward hps_io
//   sd_ack/sd_buff_wr      handshake and buffer strobe from hps_io
//   sd_buff_din            granted drive's write data, 0 when not granted
//   busy                   FSM not idle
module sd_drive_arbiter
    import einstein_sd_pkg::*;
#(
    parameter logic [23:0] ACK_TIMEOUT = 24'd16_000_000
) (
    input  logic                       clk_sys,
    input  logic                       reset_n,
    input  logic [NUM_DRIVES-1:0]      drv_rd,
    input  logic [NUM_DRIVES-1:0]      drv_wr,
    input  logic [NUM_DRIVES-1:0][31:0] drv_lba,
    output logic [NUM_DRIVES-1:0]      drv_done,
    output logic [NUM_DRIVES-1:0]      drv_err,
    output logic [NUM_DRIVES-1:0]      drv_buff_wr,
    input  logic [NUM_DRIVES-1:0][7:0] drv_buff_din,
    output logic [31:0]                sd_lba,
    output logic [NUM_DRIVES-1:0]      sd_rd,
    output logic [NUM_DRIVES-1:0]      sd_wr,
    input  logic                       sd_ack,
    input  logic                       sd_buff_wr,
    output logic [7:0]                 sd_buff_din,
    output logic                       busy
);

    sd_arb_state_t         state;
    sd_grant_t             grant;
    logic                  last_grant;
    logic [23:0]           tmo_cnt;
    logic [NUM_DRIVES-1:0] pending;
    logic                  pick_vld;
    logic                  pick_idx;
    logic                  active;

    assign pending = drv_rd | drv_wr;

    sd_rr_pick u_pick (
        .pending   (pending),
        .last      (last_grant),
        .gnt_valid (pick_vld),
        .gnt_idx   (pick_idx)
    );

    assign active = (state == REQ) || (state == XFER);
    assign busy   = (state != IDLE);
    assign sd_lba = grant.lba;
    assign sd_rd  = (active && grant.dir == DIR_RD) ? drv_onehot(grant.idx) : '0;
    assign sd_wr  = (active && grant.dir == DIR_WR) ? drv_onehot(grant.idx) : '0;

    assign sd_buff_din = active ? drv_buff_din[grant.idx] : 8'd0;

    for (genvar i = 0; i < NUM_DRIVES; i++) begin : g_drv
        assign drv_buff_wr[i] = sd_buff_wr && (state == XFER) && (grant.idx == 1'(i));
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= 1'b1;
            tmo_cnt    <= '0;
            drv_done   <= '0;
            drv_err    <= '0;
        end else begin
            drv_done <= '0;
            drv_err  <= '0;
            case (state)
                IDLE: begin
                    // A nonzero drv_done here means a timeout just ended;
                    // its requester is still dropping the request on this
                    // edge, so skip one arbitration to avoid regranting it.
                    if (!sd_ack && drv_done == '0 && pick_vld) begin
                        grant.idx  <= pick_idx;
                        grant.dir  <= drv_rd[pick_idx] ? DIR_RD : DIR_WR;
                        grant.lba  <= drv_lba[pick_idx];
                        last_grant <= pick_idx;
                        tmo_cnt    <= '0;
                        state      <= REQ;
                    end
                end
                REQ: begin
                    if (sd_ack) begin
                        state <= XFER;
                    end else if (tmo_cnt == ACK_TIMEOUT - 24'd1) begin
                        drv_done <= drv_onehot(grant.idx);
                        drv_err  <= drv_onehot(grant.idx);
                        state    <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 24'd1;
                    end
                end
                XFER: begin
                    if (!sd_ack) begin
                        drv_done <= drv_onehot(grant.idx);
                        state    <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
